alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Registered, parametrised ALU control unit for the pipelined MIPS core. Sits between ID and EX.
- Decodes {ALUOp, ALUFunction} into the ALU operation code, plus the Shamt and JumpReg selector bits, into a pipeline register.
- Adds multi-cycle MULT/DIV sequencing: a latency counter, a busy/stall handshake toward hazard control, and a one-cycle completion pulse.

Parameters:
- OP_W, 3: ALUOp width from main control; must be >= 3.
- MUL_CYCLES, 4: EX cycles for MULT/MULTU; range 2..(2^CNT_W - 1).
- DIV_CYCLES, 8: EX cycles for DIV/DIVU; range 2..(2^CNT_W - 1).
- CNT_W, 4: latency counter width.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous active-high reset
- valid_in  in  1  ID stage presents a valid instruction
- ALUOp  in  OP_W  class code from main control
- ALUFunction  in  6  instruction funct field
- hold_in  in  1  downstream stall; freezes the output register
- ready_out  out  1  instruction accepted this cycle when valid_in=1
- valid_out  out  1  output register holds a newly accepted instruction
- ALUOperation  out  4  ALU operation code
- Shamt  out  1  ALU B operand is shamt (SLL/SRL)
- JumpReg_Selector  out  1  JR selected
- md_busy  out  1  multi-cycle op in progress; drives pipeline stall
- md_done  out  1  one-cycle pulse; HI/LO result is valid

Behaviour:
- Reset (synchronous, dominant over all inputs, including mid-operation):
  - All outputs 0, FSM to IDLE, counter 0.
  - An in-flight MULT/DIV is abandoned; md_done does not pulse.
- Decode (ALUOp low 3 bits; upper bits must be 0, otherwise default):
  - R-type (ALUOp=111), by funct:
    - AND 100100 -> 0000
    - OR 100101 -> 0001
    - NOR 100111 -> 0010
    - ADD 100000 -> 0011
    - SUB 100010 -> 0100
    - SLL 000000 -> 0110, Shamt=1
    - SRL 000010 -> 0111, Shamt=1
    - JR 001000 -> 0000, JumpReg_Selector=1
    - MULT 011000 / MULTU 011001 -> 1010
    - DIV 011010 / DIVU 011011 -> 1011
  - I-type, funct ignored:
    - 100 ADDI -> 0011
    - 101 ORI -> 0001
    - 110 LUI -> 0101
    - 001 branch -> 0100
    - 010 ANDI -> 0000
    - 000 LW/SW -> 0011
  - Any other combination -> 1001, Shamt=0, JumpReg_Selector=0.
- Handshake:
  - ready_out = (state==IDLE) && !hold_in (combinational).
  - Accept = valid_in && ready_out.
  - On accept: decoded fields are registered; valid_out=1 on the next cycle (latency 1).
  - No accept and !hold_in: valid_out <= 0 (bubble); other decode fields keep their last value.
  - hold_in=1: ALUOperation, Shamt, JumpReg_Selector and valid_out all hold.
- FSM: IDLE, BUSY.
  - IDLE -> BUSY: on accept of MULT/MULTU (counter <= MUL_CYCLES-1) or DIV/DIVU (counter <= DIV_CYCLES-1).
  - BUSY: counter decrements every cycle, independent of hold_in. md_busy=1. ALUOperation holds 1010/1011.
  - BUSY -> IDLE: on the edge where counter==0. md_done=1 for exactly the following cycle; md_busy=0 in that cycle.
  - Result: md_busy is high for exactly MUL_CYCLES (or DIV_CYCLES) cycles, starting the cycle after accept.
  - valid_in while in BUSY is ignored (ready_out=0); upstream must hold the instruction.
  - In the md_done cycle, state is IDLE, so a new instruction may be accepted in that same cycle.
- Width rules: the counter saturates at 0 and never wraps. Parameters outside their legal range are a configuration error (elaboration assertion).

Optional Feature:
- Macro ALUCTRL_SLT_EN.
- Defined:
  - R-type SLT (funct 101010) -> 1000.
  - ALUOp=011 (SLTI) -> 1000.
- Undefined: both fall to the default, 1001.
- All other behaviour is identical in both builds.

Test Plan:
- Reset is held 2 cycles while valid_in=1 with ADD -> all outputs 0. The first edge after reset deasserts accepts ADD: next cycle ALUOperation=0011, valid_out=1, ready_out=1.
- Back-to-back SLL, SRL, JR, then ORI (ALUOp=101, funct=xxxxxx) -> consecutive cycles show 0110/Shamt=1, 0111/Shamt=1, 0000/JumpReg_Selector=1, then 0001 with both selector bits 0.
- MULT with MUL_CYCLES=4, ADD held on valid_in afterwards -> md_busy high for 4 cycles and ready_out=0 throughout. md_done pulses for 1 cycle, during which ADD is accepted. ALUOperation=0011 the next cycle.
- DIV with DIV_CYCLES=8, hold_in=1 for cycles 3-5 -> md_done still arrives 9 cycles after the accept edge. ALUOperation holds 1011 throughout.
- Reset asserted in cycle 2 of a DIV -> next cycle md_busy=0, state IDLE, no md_done pulse, ready_out=1.
- ALUOp=111, funct=101010 -> ALUOperation=1000 with ALUCTRL_SLT_EN defined, 1001 without. ALUOp=011 gives the same pair of results.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered ALU control decode with MULT/DIV latency sequencing between ID and EX.
// Optional build macro ALUCTRL_SLT_EN adds SLT (R-type) and SLTI decode to 1000.
module alu_control_seq #(
  parameter int unsigned OP_W       = 3,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [OP_W-1:0] ALUOp,
  input  logic [5:0]      ALUFunction,
  input  logic            hold_in,
  output logic            ready_out,
  output logic            valid_out,
  output logic [3:0]      ALUOperation,
  output logic            Shamt,
  output logic            JumpReg_Selector,
  output logic            md_busy,
  output logic            md_done
);

  localparam int unsigned CntMax = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  if (OP_W < 3) begin : g_bad_op_w
    $error("alu_control_seq: OP_W must be >= 3");
  end
  if (MUL_CYCLES < 2 || MUL_CYCLES > CntMax) begin : g_bad_mul
    $error("alu_control_seq: MUL_CYCLES out of range for CNT_W");
  end
  if (DIV_CYCLES < 2 || DIV_CYCLES > CntMax) begin : g_bad_div
    $error("alu_control_seq: DIV_CYCLES out of range for CNT_W");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic [3:0] dec_op;
  logic       dec_shamt;
  logic       dec_jr;
  logic       dec_mul;
  logic       dec_div;
  logic       op_hi_zero;
  logic       accept;

  // Wide ALUOp encodings are only legal with all bits above [2:0] clear.
  assign op_hi_zero = ((ALUOp >> 3) == '0);

  always_comb begin
    dec_op    = 4'b1001;
    dec_shamt = 1'b0;
    dec_jr    = 1'b0;
    dec_mul   = 1'b0;
    dec_div   = 1'b0;
    if (op_hi_zero) begin
      case (ALUOp[2:0])
        3'b111: begin
          case (ALUFunction)
            6'b100100: dec_op = 4'b0000;
            6'b100101: dec_op = 4'b0001;
            6'b100111: dec_op = 4'b0010;
            6'b100000: dec_op = 4'b0011;
            6'b100010: dec_op = 4'b0100;
            6'b000000: begin dec_op = 4'b0110; dec_shamt = 1'b1; end
            6'b000010: begin dec_op = 4'b0111; dec_shamt = 1'b1; end
            6'b001000: begin dec_op = 4'b0000; dec_jr    = 1'b1; end
            6'b011000, 6'b011001: begin dec_op = 4'b1010; dec_mul = 1'b1; end
            6'b011010, 6'b011011: begin dec_op = 4'b1011; dec_div = 1'b1; end
`ifdef ALUCTRL_SLT_EN
            6'b101010: dec_op = 4'b1000;
`endif
            default: dec_op = 4'b1001;
          endcase
        end
        3'b100:  dec_op = 4'b0011;
        3'b101:  dec_op = 4'b0001;
        3'b110:  dec_op = 4'b0101;
        3'b001:  dec_op = 4'b0100;
        3'b010:  dec_op = 4'b0000;
        3'b000:  dec_op = 4'b0011;
`ifdef ALUCTRL_SLT_EN
        3'b011:  dec_op = 4'b1000;
`endif
        default: dec_op = 4'b1001;
      endcase
    end
  end

  // Gated by reset so every output reads 0 while reset is asserted.
  assign ready_out = (state == StIdle) && !hold_in && !reset;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= StIdle;
      cnt              <= '0;
      valid_out        <= 1'b0;
      ALUOperation     <= 4'b0000;
      Shamt            <= 1'b0;
      JumpReg_Selector <= 1'b0;
      md_busy          <= 1'b0;
      md_done          <= 1'b0;
    end else begin
      md_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept && (dec_mul || dec_div)) begin
            state   <= StBusy;
            cnt     <= dec_mul ? MulLoad : DivLoad;
            md_busy <= 1'b1;
          end
        end
        StBusy: begin
          // Counts regardless of hold_in; exits on the edge that sees zero.
          if (cnt == '0) begin
            state   <= StIdle;
            md_busy <= 1'b0;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= StIdle;
      endcase

      if (accept) begin
        ALUOperation     <= dec_op;
        Shamt            <= dec_shamt;
        JumpReg_Selector <= dec_jr;
        valid_out        <= 1'b1;
      end else if (!hold_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench: directed vector table for the multi-cycle corners, then random
// stimulus compared against a cycle-count reference model.
module tb_alu_control_seq;

  localparam int MulCycles = 4;
  localparam int DivCycles = 8;
`ifdef ALUCTRL_SLT_EN
  localparam logic [3:0] SltCode = 4'b1000;
`else
  localparam logic [3:0] SltCode = 4'b1001;
`endif

  logic       clk = 1'b0;
  logic       reset, valid_in, hold_in;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic       ready_out, valid_out, Shamt, JumpReg_Selector, md_busy, md_done;
  logic [3:0] ALUOperation;

  always #5 clk = ~clk;

  alu_control_seq #(
    .OP_W       (3),
    .MUL_CYCLES (MulCycles),
    .DIV_CYCLES (DivCycles),
    .CNT_W      (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .ALUOp            (ALUOp),
    .ALUFunction      (ALUFunction),
    .hold_in          (hold_in),
    .ready_out        (ready_out),
    .valid_out        (valid_out),
    .ALUOperation     (ALUOperation),
    .Shamt            (Shamt),
    .JumpReg_Selector (JumpReg_Selector),
    .md_busy          (md_busy),
    .md_done          (md_done)
  );

  typedef struct {
    logic       rst, vld, hold;
    logic [2:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic [3:0] eop;
    logic       esh, ejr, evo, ebusy, edone;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles plus last-registered fields.
  int         m_left = 0;
  logic [3:0] m_op = 4'd0;
  logic       m_sh = 1'b0, m_jr = 1'b0, m_vo = 1'b0, m_done = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output logic sh,
                                     output logic jr);
    int f = int'(fn);
    code = 4'b1001; sh = 1'b0; jr = 1'b0;
    if (op == 3'd7) begin
      if (f == 36) code = 4'd0;
      else if (f == 37) code = 4'd1;
      else if (f == 39) code = 4'd2;
      else if (f == 32) code = 4'd3;
      else if (f == 34) code = 4'd4;
      else if (f == 0) begin code = 4'd6; sh = 1'b1; end
      else if (f == 2) begin code = 4'd7; sh = 1'b1; end
      else if (f == 8) begin code = 4'd0; jr = 1'b1; end
      else if (f == 24 || f == 25) code = 4'd10;
      else if (f == 26 || f == 27) code = 4'd11;
      else if (f == 42) code = SltCode;
    end else if (op == 3'd4 || op == 3'd0) code = 4'd3;
    else if (op == 3'd5) code = 4'd1;
    else if (op == 3'd6) code = 4'd5;
    else if (op == 3'd1) code = 4'd4;
    else if (op == 3'd2) code = 4'd0;
    else if (op == 3'd3) code = SltCode;
  endfunction

  function automatic logic m_ready();
    return (m_left == 0) && !hold_in && !reset;
  endfunction

  task automatic model_edge();
    logic [3:0] code;
    logic       sh, jr, acc;
    ref_decode(ALUOp, ALUFunction, code, sh, jr);
    acc = valid_in && m_ready();
    if (reset) begin
      m_left = 0; m_op = 4'd0; m_sh = 1'b0; m_jr = 1'b0; m_vo = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (acc && code == 4'd10) m_left = MulCycles;
      else if (acc && code == 4'd11) m_left = DivCycles;
      if (acc) begin
        m_op = code; m_sh = sh; m_jr = jr; m_vo = 1'b1;
      end else if (!hold_in) m_vo = 1'b0;
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    reset = v.rst; valid_in = v.vld; hold_in = v.hold; ALUOp = v.op; ALUFunction = v.fn;
    #1;
    chk("ready_out", {3'b0, ready_out}, {3'b0, use_tbl ? v.rdy : m_ready()});
    @(posedge clk);
    model_edge();
    #1;
    if (use_tbl) begin
      chk("ALUOperation", ALUOperation, v.eop);
      chk("Shamt", {3'b0, Shamt}, {3'b0, v.esh});
      chk("JumpReg_Selector", {3'b0, JumpReg_Selector}, {3'b0, v.ejr});
      chk("valid_out", {3'b0, valid_out}, {3'b0, v.evo});
      chk("md_busy", {3'b0, md_busy}, {3'b0, v.ebusy});
      chk("md_done", {3'b0, md_done}, {3'b0, v.edone});
    end else begin
      chk("ALUOperation", ALUOperation, m_op);
      chk("Shamt", {3'b0, Shamt}, {3'b0, m_sh});
      chk("JumpReg_Selector", {3'b0, JumpReg_Selector}, {3'b0, m_jr});
      chk("valid_out", {3'b0, valid_out}, {3'b0, m_vo});
      chk("md_busy", {3'b0, md_busy}, {3'b0, m_left > 0});
      chk("md_done", {3'b0, md_done}, {3'b0, m_done});
    end
  endtask

  function automatic vec_t mk(input logic rst, vld, hold, input logic [2:0] op,
                              input logic [5:0] fn, input logic rdy, input logic [3:0] eop,
                              input logic esh, ejr, evo, ebusy, edone);
    vec_t v;
    v.rst = rst; v.vld = vld; v.hold = hold; v.op = op; v.fn = fn; v.rdy = rdy;
    v.eop = eop; v.esh = esh; v.ejr = ejr; v.evo = evo; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //           rst vld hld op    fn         rdy eop   sh jr vo bsy dn
    tbl.push_back(mk(1, 1, 0, 3'd7, 6'b100000, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 3'd7, 6'b100000, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 1, 4'h3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b000000, 1, 4'h6, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b000010, 1, 4'h7, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b001000, 1, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd5, 6'b111111, 1, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'd7, 6'b100000, 1, 4'h1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3'd7, 6'b100000, 0, 4'h1, 0, 0, 0, 0, 0));
    // MULT, then ADD waiting on valid_in until the md_done cycle.
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b011000, 1, 4'hA, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 0, 4'hA, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 0, 4'hA, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 0, 4'hA, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 0, 4'hA, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b100000, 1, 4'h3, 0, 0, 1, 0, 0));
    // DIV with hold_in during busy cycles 3-5.
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b011010, 1, 4'hB, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 1, 4'hB, 0, 0, 0, 0, 0));
    // DIV abandoned by reset in its second busy cycle.
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b011011, 1, 4'hB, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 0, 4'hB, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd0, 6'b000000, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 6'b000000, 1, 4'h0, 0, 0, 0, 0, 0));
    // SLT / SLTI, build-dependent result.
    tbl.push_back(mk(0, 1, 0, 3'd7, 6'b101010, 1, SltCode, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3'd3, 6'b000000, 1, SltCode, 0, 0, 1, 0, 0));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      vec_t       v;
      logic [5:0] picks[12];
      picks = '{6'd36, 6'd37, 6'd39, 6'd32, 6'd34, 6'd0, 6'd2, 6'd8, 6'd24, 6'd27, 6'd42, 6'd26};
      v = mk(0, 0, 0, 3'd0, 6'd0, 0, 4'h0, 0, 0, 0, 0, 0);
      v.rst  = ($urandom_range(0, 59) == 0);
      v.vld  = ($urandom_range(0, 3) != 0);
      v.hold = ($urandom_range(0, 4) == 0);
      v.op   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) v.op = 3'd7;
      v.fn   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : picks[$urandom_range(0, 11)];
      step(v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
